// File: rtl/sap1_pkg.sv
// Shared types and constants for the SAP-1 microinstruction sequencer.
package sap1_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StT1,
        StT2,
        StT3,
        StT4,
        StT5,
        StT6,
        StHalt
    } state_e;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef struct packed {
        logic cp;
        logic ep;
        logic ea;
        logic su;
        logic eu;
        logic n_lm;
        logic n_ce;
        logic n_l1;
        logic n_e1;
        logic n_la;
        logic n_lb;
        logic n_l0;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        cp:   1'b0,
        ep:   1'b0,
        ea:   1'b0,
        su:   1'b0,
        eu:   1'b0,
        n_lm: 1'b1,
        n_ce: 1'b1,
        n_l1: 1'b1,
        n_e1: 1'b1,
        n_la: 1'b1,
        n_lb: 1'b1,
        n_l0: 1'b1
    };

endpackage

// File: rtl/sap1_ctrl_decode.sv
// Combinational decode of sequencer state and opcode into the SAP-1 control word,
// the one-hot T-state ring and the last-useful-T-state flag.
module sap1_ctrl_decode
    import sap1_pkg::*;
#(
    parameter bit FastCycle = 1'b0
) (
    input  state_e     state_i,
    input  logic [3:0] opcode_i,
    output ctrl_t      ctrl_o,
    output logic [5:0] t_o,
    output logic       last_o
);

    logic is_lda, is_add, is_sub, is_out, is_hlt, is_nop;

    always_comb begin
        is_lda = (opcode_i == OP_LDA);
        is_add = (opcode_i == OP_ADD);
        is_sub = (opcode_i == OP_SUB);
        is_out = (opcode_i == OP_OUT);
        is_hlt = (opcode_i == OP_HLT);
        is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);
    end

    always_comb begin
        ctrl_o = CTRL_IDLE;
        t_o    = 6'b000000;
        last_o = 1'b0;
        unique case (state_i)
            StT1: begin
                t_o         = 6'b000001;
                ctrl_o.ep   = 1'b1;
                ctrl_o.n_lm = 1'b0;
            end
            StT2: begin
                t_o       = 6'b000010;
                ctrl_o.cp = 1'b1;
            end
            StT3: begin
                t_o         = 6'b000100;
                ctrl_o.n_ce = 1'b0;
                ctrl_o.n_l1 = 1'b0;
                last_o      = FastCycle && is_nop;
            end
            StT4: begin
                t_o = 6'b001000;
                if (is_lda || is_add || is_sub) begin
                    ctrl_o.n_e1 = 1'b0;
                    ctrl_o.n_lm = 1'b0;
                end else if (is_out) begin
                    ctrl_o.ea   = 1'b1;
                    ctrl_o.n_l0 = 1'b0;
                end
                last_o = FastCycle && is_out;
            end
            StT5: begin
                t_o = 6'b010000;
                if (is_lda) begin
                    ctrl_o.n_ce = 1'b0;
                    ctrl_o.n_la = 1'b0;
                end else if (is_add || is_sub) begin
                    ctrl_o.n_ce = 1'b0;
                    ctrl_o.n_lb = 1'b0;
                    ctrl_o.su   = is_sub;
                end
                last_o = FastCycle && is_lda;
            end
            StT6: begin
                t_o = 6'b100000;
                if (is_add || is_sub) begin
                    ctrl_o.eu   = 1'b1;
                    ctrl_o.n_la = 1'b0;
                    ctrl_o.su   = is_sub;
                end
                last_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sap1_seq_ctrl.sv
// SAP-1 microinstruction sequencer: one FSM producing the T-state ring, control lines
// and halt flag, with idle, single-step and optional early instruction termination.
module sap1_seq_ctrl
    import sap1_pkg::*;
#(
    parameter bit          FAST_CYCLE = 1'b0,
    parameter int unsigned OP_W       = 4
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            run,
    input  logic            step_mode,
    input  logic            step_req,
    input  logic [OP_W-1:0] opcode,
    output logic [5:0]      t,
    output logic            cp,
    output logic            ep,
    output logic            ea,
    output logic            su,
    output logic            eu,
    output logic            n_lm,
    output logic            n_ce,
    output logic            n_l1,
    output logic            n_e1,
    output logic            n_la,
    output logic            n_lb,
    output logic            n_l0,
    output logic            n_hlt,
    output logic            instr_done
);

    state_e     state_q, state_d;
    ctrl_t      ctrl;
    logic       last;
    logic [3:0] op;

    assign op = opcode[3:0];

    sap1_ctrl_decode #(
        .FastCycle(FAST_CYCLE)
    ) u_decode (
        .state_i (state_q),
        .opcode_i(op),
        .ctrl_o  (ctrl),
        .t_o     (t),
        .last_o  (last)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (run && (!step_mode || step_req)) begin
                    state_d = StT1;
                end
            end
            StT1:    state_d = StT2;
            StT2:    state_d = StT3;
            StT3:    state_d = StT4;
            StT4:    state_d = StT5;
            StT5:    state_d = StT6;
            StT6:    state_d = StIdle;
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
        // Run/step inputs are only consulted at an instruction boundary.
        if (last) begin
            state_d = (run && !step_mode) ? StT1 : StIdle;
        end
        if (state_q == StT4 && op == OP_HLT) begin
            state_d = StHalt;
        end
    end

    always_comb begin
        cp         = ctrl.cp;
        ep         = ctrl.ep;
        ea         = ctrl.ea;
        su         = ctrl.su;
        eu         = ctrl.eu;
        n_lm       = ctrl.n_lm;
        n_ce       = ctrl.n_ce;
        n_l1       = ctrl.n_l1;
        n_e1       = ctrl.n_e1;
        n_la       = ctrl.n_la;
        n_lb       = ctrl.n_lb;
        n_l0       = ctrl.n_l0;
        n_hlt      = (state_q != StHalt);
        instr_done = last;
    end

endmodule
